// File: rtl/muxnx1_pkg.sv
// rtl/muxnx1_pkg.sv - shared encodings, defaults and helpers for the N-to-1 arbitrating mux
package muxnx1_pkg;

  // Arbitration mode encodings carried on the mode input
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Default geometry: four channels of byte-wide data
  localparam int N_DEF  = 4;
  localparam int W_DEF  = 8;
  localparam int SW_DEF = 2;

  // Channel index following k in a ring of n channels
  function automatic int wrap_inc(input int k, input int n);
    if (k >= n - 1) begin
      return 0;
    end
    return k + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotated-priority search: first valid channel at or after ptr, wrapping
import muxnx1_pkg::*;

module rr_pick #(
  parameter int N  = N_DEF,
  parameter int SW = SW_DEF
) (
  input  logic [N-1:0]  valid,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] index
);

  // Walk ptr, ptr+1, ..., N-1, 0, ..., ptr-1 and keep the first hit
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = 0; i < N; i++) begin
      int cand;
      cand = int'(ptr) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && valid[cand]) begin
        found = 1'b1;
        index = SW'(cand);
      end
    end
  end

endmodule

// File: rtl/muxnx1_arb.sv
// rtl/muxnx1_arb.sv - N-to-1 mux with fixed/round-robin arbitration into one output register
import muxnx1_pkg::*;

module muxnx1_arb #(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] i_data,
  input  logic [N-1:0]   i_valid,
  output logic [N-1:0]   i_ready,
  input  logic           mode,
  input  logic [SW-1:0]  s,
  output logic [W-1:0]   y,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [SW-1:0]  y_ch
);

  logic [SW-1:0] ptr;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic          fix_found;
  logic [SW-1:0] fix_idx;
  logic          grant_any;
  logic [SW-1:0] grant_idx;
  logic          load;
  logic          xfer;
  logic [W-1:0]  sel_data;
  logic [N-1:0]  ready_vec;

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_rr_pick (
    .valid (i_valid),
    .ptr   (ptr),
    .found (rr_found),
    .index (rr_idx)
  );

  // Fixed mode: grant channel s only if it exists and is valid (s >= N never matches)
  always_comb begin
    fix_found = 1'b0;
    fix_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (SW'(k) == s && i_valid[k]) begin
        fix_found = 1'b1;
        fix_idx   = SW'(k);
      end
    end
  end

  assign grant_any = (mode == MODE_RR) ? rr_found : fix_found;
  assign grant_idx = (mode == MODE_RR) ? rr_idx   : fix_idx;

  // Register can take a new item when empty or being drained this cycle
  assign load = !y_valid || y_ready;
  assign xfer = !rst && load && grant_any;

  // One-hot ready toward the granted channel; held low throughout reset
  always_comb begin
    ready_vec = '0;
    if (xfer) begin
      for (int k = 0; k < N; k++) begin
        if (SW'(k) == grant_idx) begin
          ready_vec[k] = 1'b1;
        end
      end
    end
  end

  assign i_ready = ready_vec;

  // Data path select for the granted channel
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (SW'(k) == grant_idx) begin
        sel_data = i_data[k*W +: W];
      end
    end
  end

  // Output register and round-robin pointer; reset discards any held item
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      ptr     <= '0;
    end else if (load) begin
      if (grant_any) begin
        y       <= sel_data;
        y_ch    <= grant_idx;
        y_valid <= 1'b1;
        if (mode == MODE_RR) begin
          ptr <= SW'(wrap_inc(int'(grant_idx), N));
        end
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muxnx1_arb.sv
// tb/tb_muxnx1_arb.sv - table-driven self-checking bench for muxnx1_arb
module tb_muxnx1_arb;

  logic        clk;
  logic        rst;
  logic [31:0] i_data;
  logic [3:0]  i_valid;
  logic [3:0]  i_ready;
  logic        mode;
  logic [1:0]  s;
  logic [7:0]  y;
  logic        y_valid;
  logic        y_ready;
  logic [1:0]  y_ch;

  int checks;
  int errors;

  muxnx1_arb #(.N(4), .W(8), .SW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .mode    (mode),
    .s       (s),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_ch    (y_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  s;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        yr;
    logic [3:0]  exp_ready;
    logic        exp_yv;
    logic [7:0]  exp_y;
    logic [1:0]  exp_ch;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic m, input logic [1:0] sel,
                              input logic [3:0] v, input logic [31:0] d, input logic yr,
                              input logic [3:0] er, input logic eyv, input logic [7:0] ey,
                              input logic [1:0] ec);
    vec_t t;
    t.rst = r; t.mode = m; t.s = sel; t.valid = v; t.data = d; t.yr = yr;
    t.exp_ready = er; t.exp_yv = eyv; t.exp_y = ey; t.exp_ch = ec;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  localparam logic [31:0] D1 = 32'h44_33_22_11;
  localparam logic [31:0] D2 = 32'h99_88_77_66;

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    mode    = 1'b1;
    s       = 2'd0;
    i_valid = 4'b1111;
    i_data  = D1;
    y_ready = 1'b1;

    //             rst  mode s   valid    data             yr   ready    yv   y      ch
    vecs[0]  = mk(1'b1, 1'b1, 2'd0, 4'b1111, D1,             1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vecs[1]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, D1,             1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
    vecs[2]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, D1,             1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
    vecs[3]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, D1,             1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
    vecs[4]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, D1,             1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
    vecs[5]  = mk(1'b0, 1'b1, 2'd0, 4'b1111, D1,             1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
    vecs[6]  = mk(1'b0, 1'b0, 2'd2, 4'b0100, 32'h00_A5_00_00, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2);
    vecs[7]  = mk(1'b0, 1'b0, 2'd3, 4'b0100, 32'h00_A5_00_00, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vecs[8]  = mk(1'b0, 1'b0, 2'd1, 4'b1111, D1,             1'b0, 4'b0010, 1'b1, 8'h22, 2'd1);
    vecs[9]  = mk(1'b0, 1'b0, 2'd0, 4'b0001, 32'h00_00_00_3C, 1'b1, 4'b0001, 1'b1, 8'h3C, 2'd0);
    vecs[10] = mk(1'b0, 1'b0, 2'd3, 4'b1111, D2,             1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0);
    vecs[11] = mk(1'b0, 1'b0, 2'd2, 4'b1111, D2,             1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0);
    vecs[12] = mk(1'b0, 1'b0, 2'd1, 4'b1111, D2,             1'b0, 4'b0000, 1'b1, 8'h3C, 2'd0);
    vecs[13] = mk(1'b0, 1'b0, 2'd1, 4'b1111, D2,             1'b1, 4'b0010, 1'b1, 8'h77, 2'd1);
    vecs[14] = mk(1'b0, 1'b1, 2'd0, 4'b1111, D1,             1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
    vecs[15] = mk(1'b0, 1'b1, 2'd0, 4'b0100, D1,             1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
    vecs[16] = mk(1'b0, 1'b1, 2'd0, 4'b0010, D1,             1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
    vecs[17] = mk(1'b0, 1'b1, 2'd0, 4'b1111, D1,             1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
    vecs[18] = mk(1'b0, 1'b1, 2'd0, 4'b1001, D1,             1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
    vecs[19] = mk(1'b0, 1'b1, 2'd0, 4'b0000, D1,             1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    vecs[20] = mk(1'b0, 1'b1, 2'd0, 4'b1001, D1,             1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
    vecs[21] = mk(1'b0, 1'b1, 2'd0, 4'b1111, D1,             1'b0, 4'b0000, 1'b1, 8'h11, 2'd0);

    // Asynchronous reset before any clock edge, with all channels valid
    #1 rst = 1'b1;
    #2;
    check("reset_y", -1, {24'h0, y}, 32'h0);
    check("reset_y_valid", -1, {31'h0, y_valid}, 32'h0);
    check("reset_y_ch", -1, {30'h0, y_ch}, 32'h0);
    check("reset_i_ready", -1, {28'h0, i_ready}, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst     = vecs[i].rst;
      mode    = vecs[i].mode;
      s       = vecs[i].s;
      i_valid = vecs[i].valid;
      i_data  = vecs[i].data;
      y_ready = vecs[i].yr;
      #1;
      check("i_ready", i, {28'h0, i_ready}, {28'h0, vecs[i].exp_ready});
      @(posedge clk);
      #1;
      check("y_valid", i, {31'h0, y_valid}, {31'h0, vecs[i].exp_yv});
      if (vecs[i].exp_yv) begin
        check("y", i, {24'h0, y}, {24'h0, vecs[i].exp_y});
        check("y_ch", i, {30'h0, y_ch}, {30'h0, vecs[i].exp_ch});
      end
    end

    // Reset in the middle of a stall: held item (8'h11) must vanish at once
    @(negedge clk);
    y_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_y_valid", 100, {31'h0, y_valid}, 32'h0);
    check("midrst_y", 100, {24'h0, y}, 32'h0);
    check("midrst_i_ready", 100, {28'h0, i_ready}, 32'h0);
    @(posedge clk);
    #1;
    check("midrst_hold", 101, {31'h0, y_valid}, 32'h0);

    // Release with nothing offered: no item may appear
    @(negedge clk);
    rst     = 1'b0;
    i_valid = 4'b0000;
    y_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check("post_rst_idle", 102 + c, {31'h0, y_valid}, 32'h0);
    end

    // First round-robin grant after reset starts at channel 0
    @(negedge clk);
    mode    = 1'b1;
    i_valid = 4'b1111;
    i_data  = D1;
    #1;
    check("post_rst_ready", 104, {28'h0, i_ready}, 32'h1);
    @(posedge clk);
    #1;
    check("post_rst_y_valid", 105, {31'h0, y_valid}, 32'h1);
    check("post_rst_y_ch", 105, {30'h0, y_ch}, 32'h0);
    check("post_rst_y", 105, {24'h0, y}, 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muxnx1_arb.md
MUXNX1_ARB -- requirements
Module: muxnx1_arb

Interface
REQ-001 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-002 Parameter W, default 8, data width per channel.
REQ-003 Parameter SW, default 2, select/channel-index width; SHALL equal clog2(N).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_data  input  N*W  channel k occupies bits [k*W +: W].
REQ-007 i_valid  input  N  channel k presents valid data.
REQ-008 i_ready  output  N  channel k is accepted this cycle; combinational.
REQ-009 mode  input  1  0 = fixed select by s, 1 = round-robin.
REQ-010 s  input  SW  channel select in fixed mode; ignored in round-robin mode.
REQ-011 y  output  W  registered output data.
REQ-012 y_valid  output  1  y holds an item.
REQ-013 y_ready  input  1  downstream accepts y.
REQ-014 y_ch  output  SW  source channel index of the item in y.

Function
REQ-015 The block SHALL contain one output register holding y, y_ch and y_valid.
REQ-016 load = !y_valid || y_ready; the register SHALL accept a new item only when load is 1.
REQ-017 Fixed mode: grant SHALL be channel s when i_valid[s]=1 and s<N; otherwise no grant.
REQ-018 Round-robin mode: grant SHALL be the first k with i_valid[k]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-019 i_ready[k] SHALL be 1 only when load=1 and k is granted; at most one bit of i_ready SHALL be set.
REQ-020 On transfer (i_valid[k] && i_ready[k]), the next edge SHALL load y=data[k], y_ch=k, y_valid=1; latency is 1 cycle.
REQ-021 When load=1 and no channel is granted, y_valid SHALL become 0 on the next edge.
REQ-022 While y_valid=1 and y_ready=0, y and y_ch SHALL hold stable and all i_ready SHALL be 0.
REQ-023 With y_valid=1, y_ready=1 and a grant in the same cycle, drain and reload SHALL occur on the same edge with no bubble.
REQ-024 ptr SHALL update to (k+1) mod N on every transfer in round-robin mode; it SHALL wrap from N-1 to 0.
REQ-025 ptr SHALL NOT change in fixed mode; a mode change SHALL take effect at the next grant decision with ptr retained.
REQ-026 A changed value of s while y is stalled SHALL NOT affect the held item.

Reset
REQ-027 While rst=1: y=0, y_ch=0, y_valid=0, ptr=0, and all i_ready=0, regardless of clk.
REQ-028 Reset asserted mid-transfer SHALL discard the held item; no item SHALL be emitted after rst is released until a new grant.

Structure
REQ-029 Package muxnx1_pkg SHALL hold the mode encodings (MODE_FIXED=0, MODE_RR=1) and the N/W defaults.
REQ-030 Sub-module rr_pick SHALL implement the rotated priority search (inputs: valid vector, ptr; outputs: found, index).
REQ-031 The output register and ptr SHALL reside in muxnx1_arb; rr_pick SHALL be purely combinational.

Verification
REQ-032 Reset: rst=1 with i_valid=4'b1111 -> y=0, y_valid=0, i_ready=0; after release, first y_ch=0 in RR mode.
REQ-033 Fixed: mode=0, s=2, i_data ch2=8'hA5, i_valid=4'b0100, y_ready=1 -> next cycle y=8'hA5, y_ch=2; s=3 with i_valid[3]=0 -> y_valid=0.
REQ-034 RR fairness: mode=1, i_valid=4'b1111 held, y_ready=1 -> y_ch sequence 0,1,2,3,0 with y_valid=1 every cycle.
REQ-035 Backpressure: y_ready=0 for 3 cycles with y=8'h3C -> y stays 8'h3C, i_ready=0; y_ready=1 -> next item loads the following cycle with no gap.
REQ-036 Wrap/skip: mode=1, ptr=3, i_valid=4'b0010 -> grant ch1, then ptr=2.
REQ-037 Mid-operation reset: assert rst while y_valid=1, y_ready=0 -> y_valid=0 immediately; held item is never observed.
